// File: rtl/raster_blit_counter_if.sv
// Request/response bundle between a blit requester and the raster blit counter.
// The requester side drives the sprite origin and the stall; the counter returns the memory address and the plot stream.
interface raster_blit_counter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int AW = 11
);
  logic          start;
  logic [XW-1:0] x_origin;
  logic [YW-1:0] y_origin;
  logic          mirror;
  logic          hold;
  logic [AW-1:0] addr;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output start, x_origin, y_origin, mirror, hold,
    input  addr, x_out, y_out, plot, busy, done
  );

  modport slave (
    input  start, x_origin, y_origin, mirror, hold,
    output addr, x_out, y_out, plot, busy, done
  );
endinterface

// File: rtl/raster_blit_counter.sv
// Scans a sprite row by row and emits sprite-memory addresses.
// Screen coordinates and a clipped plot strobe follow one cycle later, aligned with the memory read data.
module raster_blit_counter #(
  parameter int SPR_W = 40,
  parameter int SPR_H = 40,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int AW    = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  raster_blit_counter_if.slave bus
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [XW:0]   SCR_X    = (XW+1)'(SCR_W);
  localparam logic [YW:0]   SCR_Y    = (YW+1)'(SCR_H);
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [XW-1:0] xo_q, xo_d;
  logic [YW-1:0] yo_q, yo_d;
  logic          mir_q, mir_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          plot_q, plot_d;

  logic [XW:0]   xsum;
  logic [YW:0]   ysum;
  logic [CW-1:0] col_eff;
  logic [AW-1:0] addr_scan;

  // Sums carry one extra bit so a sprite hanging off the right/bottom edge
  // never wraps back onto the visible screen.
  assign xsum      = {1'b0, xo_q} + (XW+1)'(col_q);
  assign ysum      = {1'b0, yo_q} + (YW+1)'(row_q);
  assign col_eff   = mir_q ? (COL_LAST - col_q) : col_q;
  assign addr_scan = AW'(row_q) * AW'(SPR_W) + AW'(col_eff);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    mir_d   = mir_q;
    x_d     = x_q;
    y_d     = y_q;
    plot_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          xo_d    = bus.x_origin;
          yo_d    = bus.y_origin;
          mir_d   = bus.mirror;
          col_d   = '0;
          row_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!bus.hold) begin
          x_d    = xsum[XW-1:0];
          y_d    = ysum[YW-1:0];
          plot_d = (xsum < SCR_X) && (ysum < SCR_Y);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      mir_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      mir_q   <= mir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      plot_q  <= plot_d;
    end
  end

  assign bus.addr  = (state_q == S_SCAN) ? addr_scan : '0;
  assign bus.x_out = x_q;
  assign bus.y_out = y_q;
  assign bus.plot  = plot_q;
  assign bus.busy  = (state_q == S_SCAN) || (state_q == S_FLUSH);
  assign bus.done  = (state_q == S_FLUSH);

endmodule

// File: doc/raster_blit_counter.md
RASTER_BLIT_COUNTER -- requirements
Module: raster_blit_counter

Interface
REQ-001 Parameter SPR_W, default 40, sprite width in pixels (>=1).
REQ-002 Parameter SPR_H, default 40, sprite height in pixels (>=1).
REQ-003 Parameter SCR_W, default 160, screen width for clipping.
REQ-004 Parameter SCR_H, default 120, screen height for clipping.
REQ-005 Parameter XW, default 8, x coordinate width; YW, default 7, y coordinate width.
REQ-006 Parameter AW, default 11, sprite memory address width; SHALL satisfy 2^AW >= SPR_W*SPR_H.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  request a blit; honoured only in IDLE.
REQ-010 x_origin  input  XW  sprite top-left x, sampled on accepted start.
REQ-011 y_origin  input  YW  sprite top-left y, sampled on accepted start.
REQ-012 mirror  input  1  1 = horizontal flip (right-facing from left-facing art), sampled on accepted start.
REQ-013 hold  input  1  stall; freezes the scan for the cycle.
REQ-014 addr  output  AW  sprite memory read address (combinational from registered state).
REQ-015 x_out  output  XW  screen x of the pixel being plotted (registered).
REQ-016 y_out  output  YW  screen y of the pixel being plotted (registered).
REQ-017 plot  output  1  write strobe for VGA adapter, aligned with sprite memory data (1-cycle read latency).
REQ-018 busy  output  1  high in SCAN and FLUSH.
REQ-019 done  output  1  one-cycle pulse at completion.

Function
REQ-020 States IDLE, SCAN, FLUSH; internal col counter (0..SPR_W-1) and row counter (0..SPR_H-1).
REQ-021 IDLE + start=1: latch x_origin, y_origin, mirror; col=0, row=0; next state SCAN.
REQ-022 Start while busy SHALL be ignored (no relatch, no restart).
REQ-023 addr SHALL equal row*SPR_W + (mirror ? SPR_W-1-col : col) in SCAN; 0 in IDLE.
REQ-024 Advance cycle = SCAN and hold=0: pipeline captures x=x_origin+col, y=y_origin+row, valid=1; col increments.
REQ-025 col wrap: col=SPR_W-1 advancing -> col=0, row+1.
REQ-026 Last pixel (col=SPR_W-1, row=SPR_H-1) advancing -> state FLUSH.
REQ-027 Non-advance cycle: counters, origin, x_out, y_out retain; valid captured as 0.
REQ-028 plot = valid AND (x_origin+col) < SCR_W AND (y_origin+row) < SCR_H, sums computed at XW+1 / YW+1 bits (no wrap-around onto screen).
REQ-029 Each sprite pixel SHALL produce exactly one valid cycle, one cycle after its addr was presented, regardless of hold pattern.
REQ-030 FLUSH: plot for last pixel as per REQ-028, done=1, next state IDLE; hold ignored in FLUSH.
REQ-031 Total blit with no hold: SPR_W*SPR_H SCAN cycles + 1 FLUSH cycle; busy rises the cycle after start.
REQ-032 Start asserted in the done cycle SHALL be ignored; accepted next IDLE cycle.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, col=0, row=0, latched origin/mirror=0, valid=0.
REQ-034 During reset: addr=0, x_out=0, y_out=0, plot=0, busy=0, done=0.
REQ-035 Reset mid-blit aborts without done pulse; first start after release begins a fresh blit.

Verification
REQ-036 SPR_W=4, SPR_H=2, origin (10,20), mirror=0, no hold -> addr 0..7 over 8 cycles, plot at (10..13,20),(10..13,21), done on 9th cycle after busy rises.
REQ-037 Same with mirror=1 -> addr sequence 3,2,1,0,7,6,5,4; x_out still 10..13 in order.
REQ-038 Origin (158,119), SPR 4x2 -> plot only for (158,119),(159,119); all other 6 pixels plot=0; done still pulses.
REQ-039 hold=1 on alternate SCAN cycles -> 8 plots total, each x_out/y_out unique, busy lasts 16+1 cycles.
REQ-040 start pulsed during SCAN with different origin -> ignored; output coordinates unchanged.
REQ-041 reset=0 after 3 pixels -> outputs 0 immediately, no done; new start at (0,0) yields full 8-pixel blit.
